// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the byte-wide external memory port between instruction fetch
//   (32-bit reads) and the MEM stage (1/2/4-byte reads and writes). Each
//   access is split into little-endian byte transfers. Completion is a
//   one-cycle done pulse to the winning requester. MEM has fixed priority
//   over IF.
//
// Build option:
//   MEM_ARB_READ_OVERLAP_EN  defined   : a new read address every cycle,
//                                        so an n-byte read is done in C(n+2).
//                            undefined : two cycles per read byte, so an
//                                        n-byte read is done in C(2n+1).
//
// Ports:
//   clk, rst (sync, active high), rdy (low = freeze all state)
//   if_req/if_addr/if_abort      -> if_done/if_data        IF word read
//   mem_req/mem_we/mem_addr/mem_len/mem_wdata
//                                -> mem_done/mem_rdata     MEM access
//   arb_busy                     high in every non-IDLE state
//   mem_din, mem_dout, mem_a, mem_wr                       external byte bus
//
// Port names follow the surrounding CPU's bus; internal registers use r_,
// combinational signals use w_.

module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_abort,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        arb_busy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_RD,
    S_MEM_RD,
    S_MEM_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_owner_if;   // 1: current/last transfer belongs to IF
  logic [2:0]  r_n;          // byte count of the transfer
  logic [2:0]  r_i;          // issue index: byte currently on mem_a
  logic [2:0]  r_c;          // capture index: next assembly lane to fill
  logic        r_pend;       // mem_din this cycle belongs to byte r_c
  logic [31:0] r_mem_a;
  logic [31:0] r_wdata;
  logic [31:0] r_asm;        // read assembly register
  logic [31:0] r_if_data;
  logic [31:0] r_mem_rdata;

  logic [2:0]  w_n_mem;
  logic        w_last_cap;
  logic        w_last_wr;
  logic        w_wr;
  logic [31:0] w_asm_next;

  // Lengths other than 1 and 2 are treated as a full word.
  always_comb begin
    case (mem_len)
      3'd1:    w_n_mem = 3'd1;
      3'd2:    w_n_mem = 3'd2;
      default: w_n_mem = 3'd4;
    endcase
  end

  assign w_last_cap = r_pend && (r_c == r_n - 3'd1);
  assign w_last_wr  = (r_i == r_n - 3'd1);

  // Assembly register with the byte arriving this cycle merged into lane r_c.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_c[1:0], 3'b000} +: 8] = mem_din;
  end

  // NOTE: every signal assigned in a combinational block gets a default first
  // so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_state_next = r_state;
    if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (mem_req)                   w_state_next = mem_we ? S_MEM_WR : S_MEM_RD;
          else if (if_req && !if_abort)  w_state_next = S_IF_RD;
        end
        S_IF_RD: begin
          if (if_abort)        w_state_next = S_IDLE;
          else if (w_last_cap) w_state_next = S_DONE;
        end
        S_MEM_RD: if (w_last_cap) w_state_next = S_DONE;
        S_MEM_WR: if (w_last_wr)  w_state_next = S_DONE;
        S_DONE:   w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_if  <= 1'b0;
      r_n         <= 3'd0;
      r_i         <= 3'd0;
      r_c         <= 3'd0;
      r_pend      <= 1'b0;
      r_mem_a     <= 32'd0;
      r_wdata     <= 32'd0;
      r_asm       <= 32'd0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (w_state_next != S_IDLE) begin
            r_owner_if <= !mem_req;
            r_n        <= mem_req ? w_n_mem : 3'd4;
            r_mem_a    <= mem_req ? mem_addr : if_addr;
            r_wdata    <= mem_wdata;
            r_i        <= 3'd0;
            r_c        <= 3'd0;
            r_pend     <= 1'b0;
            r_asm      <= 32'd0;   // unfilled upper lanes read back as zero
          end
        end
        S_IF_RD, S_MEM_RD: begin
          if (r_pend) begin
            r_asm <= w_asm_next;
            r_c   <= r_c + 3'd1;
          end
          // Publish only on completion so an aborted fetch leaves if_data intact.
          if (w_last_cap) begin
            if (!r_owner_if)    r_mem_rdata <= w_asm_next;
            else if (!if_abort) r_if_data   <= w_asm_next;
          end
`ifdef MEM_ARB_READ_OVERLAP_EN
          // Issue the next address while the previous byte is returning.
          r_pend <= 1'b1;
          if (r_i != r_n - 3'd1) begin
            r_i     <= r_i + 3'd1;
            r_mem_a <= r_mem_a + 32'd1;
          end
`else
          // Alternate address cycle / capture cycle; advance after a capture.
          r_pend <= !r_pend;
          if (r_pend && (r_i != r_n - 3'd1)) begin
            r_i     <= r_i + 3'd1;
            r_mem_a <= r_mem_a + 32'd1;
          end
`endif
        end
        S_MEM_WR: begin
          if (!w_last_wr) begin
            r_i     <= r_i + 3'd1;
            r_mem_a <= r_mem_a + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // While rdy is low the strobe is withheld; the same byte goes out on resume.
  assign w_wr      = (r_state == S_MEM_WR) && rdy;
  assign mem_wr    = w_wr;
  assign mem_dout  = w_wr ? r_wdata[{r_i[1:0], 3'b000} +: 8] : 8'h00;
  assign mem_a     = r_mem_a;
  assign if_done   = (r_state == S_DONE) &&  r_owner_if;
  assign mem_done  = (r_state == S_DONE) && !r_owner_if;
  assign if_data   = r_if_data;
  assign mem_rdata = r_mem_rdata;
  assign arb_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. The external memory is a read-only
//   byte array with one cycle of read latency that pauses together with rdy.
//   Read latencies follow the build option MEM_ARB_READ_OVERLAP_EN.

module tb_mem_bus_arbiter;

`ifdef MEM_ARB_READ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam int LAT4 = OVL ? 6 : 9;   // 4-byte read done cycle
  localparam int LAT2 = OVL ? 4 : 5;   // 2-byte read done cycle
  localparam int LAT1 = 3;             // 1-byte read done cycle

  logic        clk, rst, rdy;
  logic        if_req, if_abort, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_len;
  logic        arb_busy;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem_model [0:4095];

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .arb_busy(arb_busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdy) mem_din <= mem_model[mem_a[11:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected read address in cycle Ck of an n-byte read starting at base.
  function automatic logic [31:0] exp_rd_addr(logic [31:0] base, int k, int n);
    int off;
    if (OVL) off = (k - 1 < n - 1) ? k - 1 : n - 1;
    else     off = (k - 1) / 2;
    return base + 32'(off);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (mem_a !== 32'd0)     begin n_bad++; $display("FAIL reset_mem_a: got %h expected %h", mem_a, 32'd0); end
    n_cmp++; if (mem_wr !== 1'b0)     begin n_bad++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    n_cmp++; if (arb_busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b expected 0", arb_busy); end
    n_cmp++; if ({if_done, mem_done} !== 2'b00) begin n_bad++; $display("FAIL reset_done: got %b expected 00", {if_done, mem_done}); end
    n_cmp++; if (if_data !== 32'd0)   begin n_bad++; $display("FAIL reset_if_data: got %h expected 0", if_data); end
    n_cmp++; if (mem_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_mem_rdata: got %h expected 0", mem_rdata); end
    n_cmp++; if (mem_dout !== 8'd0)   begin n_bad++; $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); end
  endtask

  task automatic test_if_read();
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 1; k <= LAT4; k++) begin
      tick();
      if (k < LAT4) begin
        n_cmp++; if (mem_a !== exp_rd_addr(32'h100, k, 4)) begin n_bad++; $display("FAIL if_rd_addr C%0d: got %h expected %h", k, mem_a, exp_rd_addr(32'h100, k, 4)); end
      end
      n_cmp++; if (if_done !== (k == LAT4)) begin n_bad++; $display("FAIL if_rd_done C%0d: got %b expected %b", k, if_done, k == LAT4); end
      n_cmp++; if ({mem_wr, mem_done} !== 2'b00) begin n_bad++; $display("FAIL if_rd_side C%0d: got %b expected 00", k, {mem_wr, mem_done}); end
    end
    if_req = 1'b0;
    n_cmp++; if (if_data !== 32'h0000_0513) begin n_bad++; $display("FAIL if_rd_data: got %h expected %h", if_data, 32'h513); end
    tick();
    n_cmp++; if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL if_rd_idle_busy: got %b expected 0", arb_busy); end
    n_cmp++; if (if_data !== 32'h0000_0513) begin n_bad++; $display("FAIL if_rd_hold: got %h expected %h", if_data, 32'h513); end
    n_cmp++; if (mem_a !== 32'h103) begin n_bad++; $display("FAIL if_rd_addr_hold: got %h expected %h", mem_a, 32'h103); end
  endtask

  task automatic test_mem_write();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_len = 3'd2; mem_wdata = 32'hAABB_CCDD;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) begin
        n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2000 + 32'(k - 1), (k == 1) ? 8'hDD : 8'hCC})
          begin n_bad++; $display("FAIL wr_byte C%0d: got wr=%b a=%h d=%h", k, mem_wr, mem_a, mem_dout); end
      end else begin
        n_cmp++; if ({mem_wr, mem_dout} !== 9'd0) begin n_bad++; $display("FAIL wr_done_bus: got wr=%b d=%h expected 0/00", mem_wr, mem_dout); end
      end
      n_cmp++; if (mem_done !== (k == 3)) begin n_bad++; $display("FAIL wr_done C%0d: got %b expected %b", k, mem_done, k == 3); end
      n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL wr_if_done C%0d: got %b expected 0", k, if_done); end
    end
    mem_req = 1'b0;
    tick();
    n_cmp++; if ({mem_done, if_done, mem_wr} !== 3'b000) begin n_bad++; $display("FAIL wr_after: got %b expected 000", {mem_done, if_done, mem_wr}); end
  endtask

  task automatic test_len_default();
    // Length 3 is a full word.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_len = 3'd3; mem_wdata = 32'h0403_0201;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 4) begin
        n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h40 + 32'(k - 1), 8'(k)})
          begin n_bad++; $display("FAIL len3_wr C%0d: got wr=%b a=%h d=%h", k, mem_wr, mem_a, mem_dout); end
      end
      n_cmp++; if (mem_done !== (k == 5)) begin n_bad++; $display("FAIL len3_done C%0d: got %b expected %b", k, mem_done, k == 5); end
    end
    mem_req = 1'b0;
    tick();
    // Length 7 read is a full word.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400; mem_len = 3'd7;
    for (int k = 1; k <= LAT4; k++) begin
      tick();
      n_cmp++; if (mem_done !== (k == LAT4)) begin n_bad++; $display("FAIL len7_done C%0d: got %b expected %b", k, mem_done, k == LAT4); end
    end
    mem_req = 1'b0;
    n_cmp++; if (mem_rdata !== 32'h4433_2211) begin n_bad++; $display("FAIL len7_data: got %h expected %h", mem_rdata, 32'h44332211); end
    tick();
    // Halfword read is zero-extended.
    mem_req = 1'b1; mem_addr = 32'h400; mem_len = 3'd2;
    for (int k = 1; k <= LAT2; k++) begin
      tick();
      n_cmp++; if (mem_done !== (k == LAT2)) begin n_bad++; $display("FAIL len2_done C%0d: got %b expected %b", k, mem_done, k == LAT2); end
    end
    mem_req = 1'b0;
    n_cmp++; if (mem_rdata !== 32'h0000_2211) begin n_bad++; $display("FAIL len2_data: got %h expected %h", mem_rdata, 32'h2211); end
    tick();
  endtask

  task automatic test_priority();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h30000; mem_len = 3'd1;
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 1; k <= LAT1; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++; if (mem_a !== 32'h30000) begin n_bad++; $display("FAIL prio_addr: got %h expected %h", mem_a, 32'h30000); end
      end
      n_cmp++; if (mem_done !== (k == LAT1)) begin n_bad++; $display("FAIL prio_mem_done C%0d: got %b expected %b", k, mem_done, k == LAT1); end
      n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL prio_if_early C%0d: got %b expected 0", k, if_done); end
    end
    mem_req = 1'b0;
    n_cmp++; if (mem_rdata !== 32'h0000_0041) begin n_bad++; $display("FAIL prio_rdata: got %h expected %h", mem_rdata, 32'h41); end
    // One IDLE cycle, then the IF read runs its full latency.
    for (int k = 1; k <= LAT4 + 1; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++; if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL prio_idle: got %b expected 0", arb_busy); end
      end
      n_cmp++; if (if_done !== (k == LAT4 + 1)) begin n_bad++; $display("FAIL prio_if_done +%0d: got %b expected %b", k, if_done, k == LAT4 + 1); end
    end
    if_req = 1'b0;
    n_cmp++; if (if_data !== 32'h0000_0513) begin n_bad++; $display("FAIL prio_if_data: got %h expected %h", if_data, 32'h513); end
    tick();
  endtask

  task automatic test_abort();
    if_req = 1'b1; if_addr = 32'h200;
    tick(); tick();
    if_abort = 1'b1;
    tick();
    n_cmp++; if ({arb_busy, if_done} !== 2'b00) begin n_bad++; $display("FAIL abort_state: got busy/done %b expected 00", {arb_busy, if_done}); end
    if_abort = 1'b0; if_req = 1'b0;
    n_cmp++; if (if_data !== 32'h0000_0513) begin n_bad++; $display("FAIL abort_data: got %h expected %h", if_data, 32'h513); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_cmp++; if ({arb_busy, if_done} !== 2'b00) begin n_bad++; $display("FAIL abort_quiet +%0d: got %b expected 00", k, {arb_busy, if_done}); end
    end
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_len = 3'd4;
    for (int k = 1; k <= LAT4; k++) begin
      tick();
      n_cmp++; if (mem_done !== (k == LAT4)) begin n_bad++; $display("FAIL abort_mem_done C%0d: got %b expected %b", k, mem_done, k == LAT4); end
    end
    mem_req = 1'b0;
    n_cmp++; if (mem_rdata !== 32'hDDCC_BBAA) begin n_bad++; $display("FAIL abort_mem_data: got %h expected %h", mem_rdata, 32'hDDCCBBAA); end
    tick();
    // Abort while idle suppresses the IF grant.
    if_req = 1'b1; if_abort = 1'b1;
    tick();
    n_cmp++; if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %b expected 0", arb_busy); end
    if_req = 1'b0; if_abort = 1'b0;
    tick();
  endtask

  task automatic test_rdy_stall();
    logic [31:0] frozen;
    if_req = 1'b1; if_addr = 32'h300;
    tick(); tick();
    frozen = exp_rd_addr(32'h300, 2, 4);
    rdy = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      tick();
      n_cmp++; if ({mem_a, mem_wr, if_done, arb_busy} !== {frozen, 3'b001})
        begin n_bad++; $display("FAIL stall_freeze +%0d: got a=%h wr=%b done=%b busy=%b expected a=%h 0 0 1", s, mem_a, mem_wr, if_done, arb_busy, frozen); end
    end
    rdy = 1'b1;
    for (int k = 3; k <= LAT4; k++) begin
      tick();
      if (k < LAT4) begin
        n_cmp++; if (mem_a !== exp_rd_addr(32'h300, k, 4)) begin n_bad++; $display("FAIL stall_addr C%0d: got %h expected %h", k, mem_a, exp_rd_addr(32'h300, k, 4)); end
      end
      n_cmp++; if (if_done !== (k == LAT4)) begin n_bad++; $display("FAIL stall_done C%0d+3: got %b expected %b", k, if_done, k == LAT4); end
    end
    if_req = 1'b0;
    n_cmp++; if (if_data !== 32'h1234_5678) begin n_bad++; $display("FAIL stall_data: got %h expected %h", if_data, 32'h12345678); end
    tick();
    // A write byte held off by rdy goes out when rdy returns.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_len = 3'd2; mem_wdata = 32'h0000_BEEF;
    tick();
    rdy = 1'b0; #1;
    n_cmp++; if ({mem_wr, mem_dout} !== 9'd0) begin n_bad++; $display("FAIL stall_wr_off: got wr=%b d=%h expected 0/00", mem_wr, mem_dout); end
    tick();
    n_cmp++; if ({mem_wr, mem_a} !== {1'b0, 32'h500}) begin n_bad++; $display("FAIL stall_wr_hold: got wr=%b a=%h expected 0/500", mem_wr, mem_a); end
    rdy = 1'b1; #1;
    n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h500, 8'hEF}) begin n_bad++; $display("FAIL stall_wr_resume: got wr=%b a=%h d=%h expected 1/500/EF", mem_wr, mem_a, mem_dout); end
    tick();
    n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h501, 8'hBE}) begin n_bad++; $display("FAIL stall_wr_b1: got wr=%b a=%h d=%h expected 1/501/BE", mem_wr, mem_a, mem_dout); end
    tick();
    n_cmp++; if (mem_done !== 1'b1) begin n_bad++; $display("FAIL stall_wr_done: got %b expected 1", mem_done); end
    mem_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3000; mem_len = 3'd4; mem_wdata = 32'h1122_3344;
    tick();
    n_cmp++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h3000, 8'h44}) begin n_bad++; $display("FAIL rstwr_b0: got wr=%b a=%h d=%h expected 1/3000/44", mem_wr, mem_a, mem_dout); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_req = 1'b0;
    n_cmp++; if ({mem_wr, mem_dout, mem_a} !== 41'd0) begin n_bad++; $display("FAIL rstwr_bus: got wr=%b d=%h a=%h expected zeros", mem_wr, mem_dout, mem_a); end
    n_cmp++; if ({if_done, mem_done, arb_busy} !== 3'b000) begin n_bad++; $display("FAIL rstwr_ctl: got %b expected 000", {if_done, mem_done, arb_busy}); end
    n_cmp++; if ({if_data, mem_rdata} !== 64'd0) begin n_bad++; $display("FAIL rstwr_data: got %h/%h expected 0/0", if_data, mem_rdata); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if ({mem_wr, mem_done} !== 2'b00) begin n_bad++; $display("FAIL rstwr_after +%0d: got %b expected 00", k, {mem_wr, mem_done}); end
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem_model[a] = 8'h00;
    mem_model[12'h100] = 8'h13; mem_model[12'h101] = 8'h05;
    mem_model[12'h102] = 8'h00; mem_model[12'h103] = 8'h00;
    mem_model[12'h200] = 8'hAA; mem_model[12'h201] = 8'hBB;
    mem_model[12'h202] = 8'hCC; mem_model[12'h203] = 8'hDD;
    mem_model[12'h300] = 8'h78; mem_model[12'h301] = 8'h56;
    mem_model[12'h302] = 8'h34; mem_model[12'h303] = 8'h12;
    mem_model[12'h400] = 8'h11; mem_model[12'h401] = 8'h22;
    mem_model[12'h402] = 8'h33; mem_model[12'h403] = 8'h44;
    mem_model[12'h000] = 8'h41;   // 0x30000 aliases here

    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; if_abort = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_len = 3'd4; mem_wdata = 32'd0;

    test_reset();
    test_if_read();
    test_mem_write();
    test_len_default();
    test_priority();
    test_abort();
    test_rdy_stall();
    test_reset_mid_write();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
